// File: rtl/edge_sched_pkg.sv
// rtl/edge_sched_pkg.sv - shared types and round-robin pick helper for edge_event_scheduler
package edge_sched_pkg;

    typedef enum logic {
        S_IDLE,
        S_OFFER
    } state_t;

    localparam int MAX_CH = 16;

    // Returns {found, idx}; searches ptr, ptr+1, ... and wraps at nch rather than at a power of two.
    function automatic logic [4:0] rr_pick(
        input logic [MAX_CH-1:0] pending,
        input logic [3:0]        ptr,
        input int                nch
    );
        logic [4:0] res;
        int         idx;
        res = '0;
        for (int k = 0; k < MAX_CH; k++) begin
            idx = int'(ptr) + k;
            if (idx >= nch) begin
                idx = idx - nch;
            end
            if ((k < nch) && !res[4] && pending[idx[3:0]]) begin
                res = {1'b1, idx[3:0]};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/edge_chan.sv
// rtl/edge_chan.sv - per-channel rising-edge detector with pending and sticky overflow flags
module edge_chan
    import edge_sched_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    input  logic en_i,
    input  logic ack_i,
    input  logic ovf_clr_i,
    output logic pend_o,
    output logic ovf_o
);

    logic sig_d_q;
    logic pend_q, pend_d;
    logic ovf_q, ovf_d;
    logic edge_det;

    always_comb begin
        edge_det = sig_i & ~sig_d_q & en_i;
        pend_d   = edge_det | (pend_q & ~ack_i);
        ovf_d    = ovf_q;
        // A collapsed edge outranks a simultaneous clear so no overflow is ever lost.
        if (edge_det && pend_q && !ack_i) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        sig_d_q <= sig_i;
        if (rst) begin
            pend_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

    assign pend_o = pend_q;
    assign ovf_o  = ovf_q;

endmodule

// File: rtl/edge_event_scheduler.sv
// rtl/edge_event_scheduler.sv - multi-channel rising-edge front end with round-robin event hand-off
module edge_event_scheduler
    import edge_sched_pkg::*;
#(
    parameter  int NCH = 4,
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] sig_i,
    input  logic [NCH-1:0] en_i,
    output logic           evt_valid_o,
    input  logic           evt_ready_i,
    output logic [CW-1:0]  evt_ch_o,
    output logic [NCH-1:0] ovf_o,
    input  logic           ovf_clr_i
);

    state_t          state_q, state_d;
    logic [CW-1:0]   ch_q, ch_d;
    logic [CW-1:0]   ptr_q, ptr_d;
    logic [NCH-1:0]  pend;
    logic [NCH-1:0]  ack;
    logic            accept;
    logic [4:0]      pick;

    assign accept = (state_q == S_OFFER) & evt_ready_i;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        assign ack[i] = accept & (ch_q == CW'(i));

        edge_chan u_chan (
            .clk       (clk),
            .rst       (rst),
            .sig_i     (sig_i[i]),
            .en_i      (en_i[i]),
            .ack_i     (ack[i]),
            .ovf_clr_i (ovf_clr_i),
            .pend_o    (pend[i]),
            .ovf_o     (ovf_o[i])
        );
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        ptr_d   = ptr_q;
        pick    = rr_pick(MAX_CH'(pend), 4'(ptr_q), NCH);
        case (state_q)
            S_IDLE: begin
                if (pick[4]) begin
                    ch_d    = CW'(pick[3:0]);
                    state_d = S_OFFER;
                end
            end
            S_OFFER: begin
                if (evt_ready_i) begin
                    state_d = S_IDLE;
                    ptr_d   = (ch_q == CW'(NCH - 1)) ? '0 : ch_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            ptr_q   <= ptr_d;
        end
    end

    assign evt_valid_o = (state_q == S_OFFER);
    assign evt_ch_o    = ch_q;

endmodule

// File: tb/tb_edge_event_scheduler.sv
// tb/tb_edge_event_scheduler.sv - directed self-checking bench for edge_event_scheduler (NCH=4 and NCH=3)
module tb_edge_event_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sig;
    logic [3:0] en;
    logic       ready;
    logic       ovf_clr;
    logic       valid;
    logic [1:0] ch;
    logic [3:0] ovf;

    logic [2:0] sig3;
    logic       valid3;
    logic [1:0] ch3;
    logic [2:0] ovf3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    edge_event_scheduler #(.NCH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .sig_i       (sig),
        .en_i        (en),
        .evt_valid_o (valid),
        .evt_ready_i (ready),
        .evt_ch_o    (ch),
        .ovf_o       (ovf),
        .ovf_clr_i   (ovf_clr)
    );

    edge_event_scheduler #(.NCH(3)) dut3 (
        .clk         (clk),
        .rst         (rst),
        .sig_i       (sig3),
        .en_i        (3'b111),
        .evt_valid_o (valid3),
        .evt_ready_i (1'b1),
        .evt_ch_o    (ch3),
        .ovf_o       (ovf3),
        .ovf_clr_i   (1'b0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sig = '0; en = 4'hF; ready = 1'b1; ovf_clr = 1'b0; sig3 = '0;
        step(2);
        rst = 1'b0;
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_ch",    32'(ch),    32'd0);
        check("rst_ovf",   32'(ovf),   32'd0);

        // Single edge on ch2
        sig = 4'b0100; step();
        check("single_not_yet", 32'(valid), 32'd0);
        step();
        check("single_valid", 32'(valid), 32'd1);
        check("single_ch",    32'(ch),    32'd2);
        step();
        check("single_drop",  32'(valid), 32'd0);
        step();
        check("single_once",  32'(valid), 32'd0);
        check("single_ovf",   32'(ovf),   32'd0);

        // Round-robin 0,1,3 then 0,1 with ptr back at 0
        sig = 4'b0000; do_reset();
        sig = 4'b1011; step(2);
        check("rr_a_ch", 32'(ch), 32'd0); check("rr_a_v", 32'(valid), 32'd1);
        step();
        check("rr_gap1", 32'(valid), 32'd0);
        step();
        check("rr_b_ch", 32'(ch), 32'd1); check("rr_b_v", 32'(valid), 32'd1);
        step(2);
        check("rr_c_ch", 32'(ch), 32'd3); check("rr_c_v", 32'(valid), 32'd1);
        step();
        sig = 4'b0000; step();
        sig = 4'b0011; step(2);
        check("rr_d_ch", 32'(ch), 32'd0); check("rr_d_v", 32'(valid), 32'd1);
        step(2);
        check("rr_e_ch", 32'(ch), 32'd1); check("rr_e_v", 32'(valid), 32'd1);
        step();
        check("rr_end1", 32'(valid), 32'd0);
        step();
        check("rr_end2", 32'(valid), 32'd0);

        // Backpressure and overflow on ch1
        sig = 4'b0000; do_reset();
        ready = 1'b0;
        sig = 4'b0010; step(2);
        check("bp_valid", 32'(valid), 32'd1);
        check("bp_ch",    32'(ch),    32'd1);
        sig = 4'b0000; step();
        check("bp_hold_ch", 32'(ch),  32'd1);
        check("bp_no_ovf",  32'(ovf), 32'd0);
        sig = 4'b0010; step();
        check("bp_ovf_set", 32'(ovf), 32'b0010);
        check("bp_hold_v",  32'(valid), 32'd1);
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        check("bp_ovf_clr", 32'(ovf), 32'd0);
        sig = 4'b0000; step();
        sig = 4'b0010; ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        check("bp_set_wins", 32'(ovf), 32'b0010);
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        check("bp_ovf_clr2", 32'(ovf), 32'd0);
        check("bp_hold_ch2", 32'(ch),  32'd1);
        ready = 1'b1; step();
        check("bp_accept", 32'(valid), 32'd0);
        step();
        check("bp_one_evt1", 32'(valid), 32'd0);
        step();
        check("bp_one_evt2", 32'(valid), 32'd0);

        // Edge coincident with accept on ch0
        sig = 4'b0000; do_reset();
        ready = 1'b0;
        sig = 4'b0001; step(2);
        check("ea_offer", 32'(ch), 32'd0); check("ea_v", 32'(valid), 32'd1);
        sig = 4'b0000; step();
        sig = 4'b0001; ready = 1'b1; step();
        check("ea_idle", 32'(valid), 32'd0);
        check("ea_ovf",  32'(ovf),   32'd0);
        step();
        check("ea_again_v",  32'(valid), 32'd1);
        check("ea_again_ch", 32'(ch),    32'd0);
        step();
        check("ea_done", 32'(valid), 32'd0);

        // Line high through reset, disabled channel
        sig = 4'b1000; en = 4'b1011; do_reset();
        sig = 4'b1100; step(3);
        check("en_no_evt", 32'(valid), 32'd0);
        check("en_no_ovf", 32'(ovf),   32'd0);
        en = 4'hF;
        sig = 4'b0000; step();
        sig = 4'b0100; step(2);
        check("en_ch2", 32'(ch), 32'd2);
        step();
        ready = 1'b0;
        sig = 4'b1101; step(2);
        check("ptr3_pick", 32'(ch), 32'd3);
        sig = 4'b1100; step();
        sig = 4'b1101; step();
        check("pre_rst_ovf", 32'(ovf), 32'b0001);
        do_reset();
        check("offer_rst_v",   32'(valid), 32'd0);
        check("offer_rst_ovf", 32'(ovf),   32'd0);
        step();
        check("offer_rst_pend", 32'(valid), 32'd0);
        sig = 4'b0000; step();
        sig = 4'b1001; step(2);
        check("rst_ptr_ch0", 32'(ch), 32'd0);
        ready = 1'b1; step(2);
        check("rst_ptr_ch3", 32'(ch), 32'd3);
        step();

        // NCH=3 wrap
        sig3 = 3'b111; step(2);
        check("n3_a", 32'(ch3), 32'd0);
        step(2);
        check("n3_b", 32'(ch3), 32'd1);
        step(2);
        check("n3_c", 32'(ch3), 32'd2); check("n3_c_v", 32'(valid3), 32'd1);
        step();
        sig3 = 3'b000; step();
        sig3 = 3'b101; step(2);
        check("n3_wrap", 32'(ch3), 32'd0); check("n3_wrap_v", 32'(valid3), 32'd1);
        step(2);
        check("n3_last", 32'(ch3), 32'd2);
        step();
        check("n3_idle", 32'(valid3), 32'd0);
        check("n3_ovf",  32'(ovf3),   32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/edge_event_scheduler.md
Name: edge_event_scheduler

Overview:
- Multi-channel rising-edge front end plus round-robin scheduler.
- Watches NCH level inputs and records one pending event per channel on each rising edge.
- Hands events one at a time to a single downstream consumer over a valid/ready port, tagged with the channel number.
- Sits between raw (already synchronised) status lines and the event-handling logic; replaces ad-hoc per-signal edge FSMs.

Parameters:
- NCH, 4, number of input channels (2..16; need not be a power of 2).
- CW, $clog2(NCH), channel-id width; derived localparam, not overridable.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- sig_i  in  NCH  per-channel level inputs, already synchronous to clk.
- en_i  in  NCH  per-channel edge-detect enable.
- evt_valid_o  out  1  event offered to the consumer.
- evt_ready_i  in  1  consumer accepts the event.
- evt_ch_o  out  CW  channel id of the offered event.
- ovf_o  out  NCH  sticky per-channel overflow flags.
- ovf_clr_i  in  1  clears all overflow flags.

Behaviour:
- Reset (rst=1 at a posedge):
  - evt_valid_o=0, evt_ch_o=0, ovf_o=0, all pending flags 0, rr pointer=0, FSM=IDLE.
  - sig_d (the delayed copy of sig_i) loads sig_i, so a line held high through reset generates no edge.
- Edge detect, per channel i: edge[i] = sig_i[i] & ~sig_d[i] & en_i[i]. sig_d updates every cycle regardless of en_i.
- Pending, per channel i:
  - Set on edge[i].
  - Cleared when channel i is accepted (evt_valid_o & evt_ready_i & evt_ch_o==i).
  - Edge and accept for i in the same cycle: pending stays 1 (new event); no overflow.
  - Edge while pending is already 1 and not being accepted: pending stays 1 and ovf_o[i] is set. Events collapse; they are not counted.
- Deasserting en_i blocks new edges only; it does not clear pending flags or overflow flags.
- ovf_clr_i clears all ovf_o bits. A set in the same cycle as ovf_clr_i wins.
- FSM states:
  - IDLE: if any pending, pick the first pending channel searching ptr, ptr+1, ..., NCH-1, 0, ... (wraps at NCH, not at 2^CW). Register evt_ch_o to that channel, set evt_valid_o=1, go to OFFER. Otherwise stay in IDLE with evt_valid_o=0.
  - OFFER: evt_valid_o and evt_ch_o hold stable until evt_ready_i=1. On acceptance: clear pending[evt_ch_o]; ptr <= evt_ch_o+1, wrapping NCH-1 to 0; evt_valid_o=0; go to IDLE.
- Latency: rising edge sampled at posedge t → pending at t → evt_valid_o high after posedge t+1 (2 cycles from the sig_i rise).
- Throughput: at most one event per 2 cycles (IDLE/OFFER alternate).
- evt_ready_i is ignored in IDLE. A channel's pending flag is never cleared without a handshake.
- Reset in OFFER: evt_valid_o drops after that posedge and the offered event is discarded.

Decomposition:
- Package edge_sched_pkg:
  - state typedef enum logic {S_IDLE, S_OFFER}.
  - Function rr_pick(pending, ptr, nch) returning {found, idx}.
- Sub-module edge_chan, one instance per channel:
  - Holds sig_d, the pending flag and the ovf flag.
  - Inputs: clk, rst, sig_i, en_i, ack_i, ovf_clr_i.
  - Outputs: pend_o, ovf_o.
- Top: generate loop of edge_chan, plus the FSM and rr pointer.

Test Plan:
- Single edge: NCH=4, en_i=4'hF, evt_ready_i=1; raise sig_i[2] at cycle 10 → evt_valid_o=1, evt_ch_o=2 visible after posedge 11; held 1 cycle; pending[2] cleared; ovf_o=0.
- Round-robin: edges on channels 0,1,3 in the same cycle, evt_ready_i=1 → events ch 0,1,3 on every other cycle; then ch1 and ch0 pending together with ptr=0 (after ch3) → order 0 then 1.
- Backpressure/overflow: evt_ready_i=0; toggle sig_i[1] 0→1→0→1 → evt_ch_o=1 held stable; ovf_o[1]=1 after the second rise; ovf_clr_i pulse → ovf_o=0; on release, exactly one event for ch1.
- Edge on accept: sig_i[0] rises in the same cycle ch0 is accepted → a second ch0 event is offered 2 cycles later; ovf_o[0]=0.
- Enable/reset: sig_i[3]=1 during rst, en_i[2]=0 while sig_i[2] rises → no events and no ovf after release; rst asserted in OFFER → evt_valid_o=0, all pending and ovf cleared, ptr=0.
- NCH=3 build: edges on all three channels → order 0,1,2, then ptr wraps to 0 (never selects id 3).
